// File: rtl/dmem_dump_engine.sv
// dmem_dump_engine: reads a window of data-memory words through a one-cycle-latency
// read port and streams them out LSB byte first on a valid/ready byte interface.
module dmem_dump_engine #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last
);

  typedef enum logic [2:0] {StIdle, StRead, StWait, StSend, StDone} state_e;

  localparam logic [ADDR_W:0] RemOne = (ADDR_W + 1)'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [1:0]          idx_q, idx_d;
  logic [DATA_W-1:0]   buf_q, buf_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    busy      = (state_q != StIdle);
    done      = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          ptr_d   = base_addr;
          rem_d   = word_count;
          state_d = (word_count == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        mem_rd_en = 1'b1;
        mem_addr  = ptr_q;
        state_d   = StWait;
      end
      StWait: begin
        buf_d   = mem_rdata;
        idx_d   = '0;
        state_d = StSend;
      end
      StSend: begin
        out_valid = 1'b1;
        out_data  = buf_q[{idx_q, 3'b000} +: 8];
        out_last  = (idx_q == 2'd3) && (rem_q == RemOne);
        if (out_ready) begin
          idx_d = idx_q + 2'd1;
          // Last byte of the word: retire it and move to the next address (wraps).
          if (idx_q == 2'd3) begin
            rem_d   = rem_q - 1'b1;
            ptr_d   = ptr_q + 1'b1;
            state_d = (rem_q == RemOne) ? StDone : StRead;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_dmem_dump_engine.sv
// Directed bench for dmem_dump_engine: a vector table of dumps against a behavioural
// memory, plus hand-written reset, data-order, wrap and abort sequences.
module tb_dmem_dump_engine;

  logic       clk = 1'b0;
  logic       rst, start, out_ready;
  logic [4:0] base_addr, mem_addr;
  logic [5:0] word_count;
  logic       busy, done, mem_rd_en, out_valid, out_last;
  logic [31:0] mem_rdata;
  logic [7:0] out_data;

  logic [31:0] mem [32];

  always #5 clk = ~clk;

  // One-cycle read latency; junk data outside the valid cycle exposes mistimed captures.
  always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr] : 32'hBAD0_BAD0;

  dmem_dump_engine #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  typedef struct {
    logic [4:0] base;
    logic [5:0] count;
    int         mode;       // 0: ready always, 1: ready 1,0,0 pattern, 2: ready + stray starts
    int         exp_bytes;
    int         exp_reads;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs [7];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] byte_q [$];
  logic       last_q [$];
  logic [4:0] rd_q   [$];
  int done_cnt, lat_valid, lat_done, stall_err, timed_out, busy_end, busy_at_done;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Entered and left at posedge+#1. Iteration k observes the state after the k-th edge,
  // where edge 1 is the one that accepts start.
  task automatic run_dump(input logic [4:0] b, input logic [5:0] c, input int mode);
    int k;
    logic pv, pr, pl;
    logic [7:0] pd;
    byte_q.delete(); last_q.delete(); rd_q.delete();
    done_cnt = 0; lat_valid = -1; lat_done = -1; stall_err = 0; timed_out = 0;
    busy_at_done = 0;
    base_addr = b; word_count = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 1; pv = 1'b0; pr = 1'b0; pd = '0; pl = 1'b0;
    forever begin
      if (lat_done >= 0 && k == lat_done + 1) break;
      if (k > 3000) begin timed_out = 1; break; end
      out_ready = (mode == 1) ? (k % 3 == 0) : 1'b1;
      start = (mode == 2) && (k == 5 || done);
      if (mode == 2 && k == 5) begin base_addr = 5'd20; word_count = 6'd3; end
      if (pv && !pr && (out_data !== pd || out_last !== pl)) stall_err++;
      if (mem_rd_en) rd_q.push_back(mem_addr);
      if (out_valid && lat_valid < 0) lat_valid = k;
      if (out_valid && out_ready) begin
        byte_q.push_back(out_data);
        last_q.push_back(out_last);
      end
      if (done) begin
        done_cnt++;
        busy_at_done = busy;
        if (lat_done < 0) lat_done = k;
      end
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    busy_end = busy;
  endtask

  initial begin
    int errs, dn, k;
    logic [7:0] exp_b;
    rst = 1'b1; start = 1'b1; base_addr = 5'd3; word_count = 6'd5; out_ready = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = '0;

    // Reset held two cycles with start asserted.
    @(posedge clk); @(posedge clk); #1;
    chk("reset busy", busy, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset mem_rd_en", mem_rd_en, 0);
    chk("reset outputs", {done, mem_addr, out_data, out_last}, 0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("post-reset idle", {busy, mem_rd_en, out_valid}, 0);

    // Basic little-endian ordering.
    mem[4] = 32'hDEADBEEF;
    run_dump(5'd4, 6'd1, 0);
    chk("basic bytes", byte_q.size(), 4);
    chk("basic reads", rd_q.size(), 1);
    while (byte_q.size() < 4) begin byte_q.push_back(8'h00); last_q.push_back(1'b0); end
    if (rd_q.size() == 0) rd_q.push_back(5'd0);
    chk("basic data", {byte_q[0], byte_q[1], byte_q[2], byte_q[3]}, 32'hEFBEADDE);
    chk("basic last", {last_q[0], last_q[1], last_q[2], last_q[3]}, 4'b0001);
    chk("basic addr", rd_q[0], 4);
    chk("basic done latency", lat_done, 7);

    // Address wrap with mem[i] = i.
    for (int i = 0; i < 32; i++) mem[i] = i;
    run_dump(5'd30, 6'd4, 0);
    chk("wrap reads", rd_q.size(), 4);
    while (rd_q.size() < 4) rd_q.push_back(5'd0);
    while (byte_q.size() < 16) byte_q.push_back(8'hFF);
    chk("wrap addrs", {rd_q[0], rd_q[1], rd_q[2], rd_q[3]}, {5'd30, 5'd31, 5'd0, 5'd1});
    chk("wrap lsbs", {byte_q[0], byte_q[4], byte_q[8], byte_q[12]}, 32'h1E1F0001);

    // Table: byte k of word i is 0x10*(k+1) + i.
    for (int i = 0; i < 32; i++)
      mem[i] = {8'(8'h40 + i), 8'(8'h30 + i), 8'(8'h20 + i), 8'(8'h10 + i)};
    vecs[0] = '{base: 5'd4,  count: 6'd1,  mode: 0, exp_bytes: 4,   exp_reads: 1,
                exp_first: 8'h14, exp_last: 8'h44};
    vecs[1] = '{base: 5'd30, count: 6'd4,  mode: 0, exp_bytes: 16,  exp_reads: 4,
                exp_first: 8'h2E, exp_last: 8'h41};
    vecs[2] = '{base: 5'd0,  count: 6'd32, mode: 0, exp_bytes: 128, exp_reads: 32,
                exp_first: 8'h10, exp_last: 8'h5F};
    vecs[3] = '{base: 5'd10, count: 6'd0,  mode: 0, exp_bytes: 0,   exp_reads: 0,
                exp_first: 8'h00, exp_last: 8'h00};
    vecs[4] = '{base: 5'd7,  count: 6'd2,  mode: 1, exp_bytes: 8,   exp_reads: 2,
                exp_first: 8'h17, exp_last: 8'h48};
    vecs[5] = '{base: 5'd31, count: 6'd2,  mode: 1, exp_bytes: 8,   exp_reads: 2,
                exp_first: 8'h2F, exp_last: 8'h40};
    vecs[6] = '{base: 5'd0,  count: 6'd2,  mode: 2, exp_bytes: 8,   exp_reads: 2,
                exp_first: 8'h10, exp_last: 8'h41};

    for (int v = 0; v < 7; v++) begin
      run_dump(vecs[v].base, vecs[v].count, vecs[v].mode);
      chk($sformatf("v%0d timeout", v), timed_out, 0);
      chk($sformatf("v%0d byte count", v), byte_q.size(), vecs[v].exp_bytes);
      chk($sformatf("v%0d read count", v), rd_q.size(), vecs[v].exp_reads);
      chk($sformatf("v%0d done pulses", v), done_cnt, 1);
      chk($sformatf("v%0d busy at done", v), busy_at_done, 1);
      chk($sformatf("v%0d busy after", v), busy_end, 0);
      chk($sformatf("v%0d stall stability", v), stall_err, 0);
      if (vecs[v].mode != 1)
        chk($sformatf("v%0d done latency", v), lat_done, 6 * int'(vecs[v].count) + 1);
      if (vecs[v].exp_bytes > 0 && byte_q.size() > 0) begin
        chk($sformatf("v%0d valid latency", v), lat_valid, 3);
        chk($sformatf("v%0d first byte", v), byte_q[0], vecs[v].exp_first);
        chk($sformatf("v%0d last byte", v), byte_q[byte_q.size() - 1], vecs[v].exp_last);
      end else begin
        chk($sformatf("v%0d no valid", v), lat_valid, -1);
      end
      errs = 0;
      for (int j = 0; j < byte_q.size(); j++) begin
        exp_b = 8'(((j % 4) + 1) * 16 + ((int'(vecs[v].base) + j / 4) % 32));
        if (byte_q[j] !== exp_b) errs++;
        if (last_q[j] !== (j == byte_q.size() - 1)) errs++;
      end
      for (int j = 0; j < rd_q.size(); j++)
        if (rd_q[j] !== 5'((int'(vecs[v].base) + j) % 32)) errs++;
      chk($sformatf("v%0d stream errors", v), errs, 0);
    end

    // Abort at byte index 2, then a normal dump.
    mem[4] = 32'hDEADBEEF;
    out_ready = 1'b1; base_addr = 5'd4; word_count = 6'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!(out_valid && out_data == 8'hAD) && k < 20) begin @(posedge clk); #1; k++; end
    chk("abort reached idx2", int'(out_valid && out_data == 8'hAD), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort outputs", {out_valid, out_data, out_last, mem_rd_en}, 0);
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) dn++;
      @(posedge clk); #1;
    end
    chk("abort no done", dn, 0);
    run_dump(5'd4, 6'd1, 0);
    chk("post-abort bytes", byte_q.size(), 4);
    if (byte_q.size() == 0) byte_q.push_back(8'h00);
    chk("post-abort first", byte_q[0], 8'hEF);
    chk("post-abort done", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
